booth_mul_seq: RTL and testbench

Parametrised sequential radix-4 Booth multiplier. It accepts one WIDTH×WIDTH operand pair over a valid/ready handshake and retires one Booth digit per clock. It returns the full 2·WIDTH-bit product over a second valid/ready handshake. It sits in the ALU datapath alongside the combinational adder blocks, replacing single-shot multiplication where area matters more than latency.

---
 rtl/booth_mul_seq.sv | 163 ++++++++++++++++
 tb/tb_booth_mul_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_seq.sv
// booth_mul_seq: sequential radix-4 Booth multiplier, one Booth digit per clock.
// Optional feature macro: BOOTH_MUL_UNSIGNED_EN enables per-operation unsigned mode
// (in_signed sampled at accept); without it every operation is signed.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. in_ready, out_valid and busy come straight from registers, so no input
// reaches them combinationally. Once out_valid is high, out_p stays stable until
// the transfer completes.
module booth_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic                 busy,
    output logic [1:0]           dbg_state
);

    // Accumulator carries headroom beyond the 2*WIDTH product.
    localparam int AW = 2 * WIDTH + 4;
    // Digits in signed mode; unsigned mode uses one more.
    localparam int NS = WIDTH / 2;
    localparam int CW = $clog2(NS + 2);
    // Multiplier register: 2 extension bits, WIDTH bits, and the b[-1] = 0 bit.
    localparam int MW = WIDTH + 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [AW-1:0]      acc_q;
    logic [AW-1:0]      acc_d;
    logic [AW-1:0]      mcand_q;
    logic [AW-1:0]      pp;
    logic [MW-1:0]      mplr_q;
    logic [CW-1:0]      cnt_q;
    logic [CW-1:0]      last_cnt;
    logic [2*WIDTH-1:0] p_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;
    logic               accept;
    logic               accept_signed;
    logic               op_signed;
    logic               a_sign;
    logic               b_sign;

    assign accept = in_valid && in_ready_q;

`ifdef BOOTH_MUL_UNSIGNED_EN
    logic sgn_q;

    assign accept_signed = in_signed;
    assign op_signed     = sgn_q;

    // Capture the signedness of the operation at the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sgn_q <= 1'b1;
        end else if (accept) begin
            sgn_q <= in_signed;
        end
    end
`else
    logic unused_in_signed;

    assign unused_in_signed = in_signed;
    assign accept_signed    = 1'b1;
    assign op_signed        = 1'b1;
`endif

    // Sign bits used for extension; zero in unsigned mode.
    assign a_sign = accept_signed & in_a[WIDTH-1];
    assign b_sign = accept_signed & in_b[WIDTH-1];

    // Unsigned mode runs one extra digit to cover the zero-extended top bits.
    assign last_cnt = op_signed ? CW'(NS - 1) : CW'(NS);

    // Decode the current Booth triplet into a partial product of the shifted multiplicand.
    always_comb begin
        pp = '0;
        case (mplr_q[2:0])
            3'b001, 3'b010: pp = mcand_q;
            3'b011:         pp = mcand_q << 1;
            3'b100:         pp = -(mcand_q << 1);
            3'b101, 3'b110: pp = -mcand_q;
            default:        pp = '0;
        endcase
    end

    assign acc_d = acc_q + pp;

    // Control FSM and datapath registers; multiplicand shifts left so each digit lands at weight 4^k.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplr_q      <= '0;
            cnt_q       <= '0;
            p_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        acc_q      <= '0;
                        mcand_q    <= {{(AW - WIDTH){a_sign}}, in_a};
                        mplr_q     <= {{2{b_sign}}, in_b, 1'b0};
                        cnt_q      <= '0;
                        state_q    <= CALC;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                CALC: begin
                    acc_q   <= acc_d;
                    mcand_q <= mcand_q << 2;
                    mplr_q  <= {2'b00, mplr_q[MW-1:2]};
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == last_cnt) begin
                        p_q         <= acc_d[2*WIDTH-1:0];
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_p     = p_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Testbench for booth_mul_seq (WIDTH=16): directed corner cases plus a random stream
// checked against an arithmetic reference model through an expected-product queue.
`timescale 1ns/1ps
module tb_booth_mul_seq;
  localparam int W = 16;
  localparam int NSIG = W / 2;
`ifdef BOOTH_MUL_UNSIGNED_EN
  localparam bit UNS_EN = 1'b1;
`else
  localparam bit UNS_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_signed = 1'b1;
  logic out_ready = 1'b1;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic in_ready, out_valid, busy;
  logic [2*W-1:0] out_p;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  booth_mul_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [2*W-1:0] exp_q[$];
  int t0_q[$];
  int n_q[$];
  int checks = 0;
  int errors = 0;
  bit rand_ready = 1'b0;
  bit ov_prev = 1'b0;
  bit hold_pend = 1'b0;
  logic [2*W-1:0] hold_val = '0;
  int mon_t0, mon_n;
  logic [2*W-1:0] mon_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: the mathematical product of the operands in the selected mode.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic signed [2*W-1:0] sa, sb;
    logic [2*W-1:0] ua, ub;
    if (s || !UNS_EN) begin
      sa = {{W{a[W-1]}}, a};
      sb = {{W{b[W-1]}}, b};
      return sa * sb;
    end
    ua = {{W{1'b0}}, a};
    ub = {{W{1'b0}}, b};
    return ua * ub;
  endfunction

  function automatic int latency(input logic s);
    return (UNS_EN && !s) ? NSIG + 1 : NSIG;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev = 1'b0;
      hold_pend = 1'b0;
    end else begin
      check("status_onehot", 64'($countones({in_ready, busy, out_valid})), 64'd1);
      if (out_valid && !ov_prev) begin
        if (t0_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_out_valid: got out_valid=1 expected no pending operation (t=%0t)", $time);
        end else begin
          mon_t0 = t0_q.pop_front();
          mon_n = n_q.pop_front();
          check("latency", 64'(cyc - mon_t0), 64'(mon_n));
        end
      end
      if (hold_pend && out_valid) check("out_p_hold", out_p, hold_val);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_product: got %h expected no product (t=%0t)", out_p, $time);
        end else begin
          mon_exp = exp_q.pop_front();
          check("product", out_p, mon_exp);
        end
      end
      hold_pend = out_valid && !out_ready;
      hold_val = out_p;
      ov_prev = out_valid;
    end
  end

  // Random output backpressure during the stream phase.
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; holds in_valid until the pair is accepted.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [2*W-1:0] req);
    int guard;
    guard = 0;
    in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      guard++;
      if (guard > 300) begin
        checks++; errors++;
        $display("FAIL accept_timeout: got in_ready=0 expected 1 within 300 cycles");
        in_valid = 1'b0;
        return;
      end
    end
    exp_q.push_back(req);
    t0_q.push_back(cyc + 1);
    n_q.push_back(latency(s));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = W'($urandom);
    in_b = W'($urandom);
    in_signed = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk); #1;
      guard++;
      if (guard > 500) begin
        checks++; errors++;
        $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        exp_q.delete(); t0_q.delete(); n_q.delete();
        return;
      end
    end
  endtask

  logic [W-1:0] corners[5] = '{16'h8000, 16'h7FFF, 16'h0000, 16'h0001, 16'hFFFF};

  function automatic logic [W-1:0] pick();
    if ($urandom_range(0, 7) == 0) return corners[$urandom_range(0, 4)];
    return W'($urandom);
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int seen;
    int guard;
    logic [W-1:0] ra, rb;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_out_p", out_p, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // -3 * 7, then in_ready back the cycle after the output handshake
    out_ready = 1'b1;
    issue(16'hFFFD, 16'h0007, 1'b1, 32'hFFFFFFEB);
    drain();
    @(posedge clk); #1;
    check("in_ready_after_handshake", in_ready, 1);

    // signed extremes
    issue(16'h8000, 16'h8000, 1'b1, 32'h40000000);
    issue(16'h7FFF, 16'h8000, 1'b1, 32'hC0008000);
    drain();

`ifdef BOOTH_MUL_UNSIGNED_EN
    issue(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
    issue(16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001);
`else
    issue(16'hFFFF, 16'hFFFF, 1'b0, 32'h00000001);
`endif
    drain();
    @(posedge clk); #1;

    // backpressure: 5*6 held in DONE for 20 cycles, in_valid pulses ignored
    out_ready = 1'b0;
    issue(16'd5, 16'd6, 1'b1, 32'd30);
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("bp_out_valid_rise", out_valid, 1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom_range(0, 1));
      in_a = W'($urandom);
      in_b = W'($urandom);
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_p", out_p, 30);
      check("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    @(posedge clk); #1;
    issue(16'd9, 16'hFFF5, 1'b1, 32'hFFFFFF9D);
    drain();
    @(posedge clk); #1;

    // reset three cycles into CALC
    issue(16'd1234, 16'd567, 1'b1, 32'h000AAD1E);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_out_p", out_p, 0);
    check("async_rst_in_ready", in_ready, 1);
    exp_q.delete(); t0_q.delete(); n_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no_output_after_reset", 64'(seen), 0);
    @(posedge clk); #1;
    issue(16'd100, 16'hFF9C, 1'b1, 32'hFFFFD8F0);
    drain();
    @(posedge clk); #1;

    // random stream of signed pairs with input gaps and output stalls
    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      ra = pick();
      rb = pick();
      issue(ra, rb, 1'b1, model(ra, rb, 1'b1));
    end
    rand_ready = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("pending_latency_entries", 64'(t0_q.size()), 0);
    check("final_idle", in_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached with %0d checks done", checks);
    $fatal(1, "watchdog");
  end

endmodule
